pc_unit: RTL and testbench
==========================

// Module: pc_unit
//
// PURPOSE
//  Parametrised program-counter unit: the PC register, its incrementer and the
//  next-PC selection in one block. Handles sequential fetch, taken branch,
//  jump, call/return via an internal return-address stack (RAS), trap
//  redirect, and pipeline stall. Feeds the instruction-fetch address.
//
// PARAMETERS
//  WIDTH      32     PC / target width in bits
//  INC        4      sequential increment (bytes per instruction)
//  ALIGN_BITS 2      low target bits forced to 0 on every redirect
//  RESET_VEC  0      PC value loaded on reset
//  TRAP_VEC   'h80   PC value loaded on trap or RAS underflow
//  RAS_DEPTH  4      return-address stack entries (>=2)
//
// PORTS
//  CLK        in   1      clock; all state changes on rising edge
//  RESET_N    in   1      asynchronous active-low reset
//  STALL      in   1      hold PC and RAS this cycle (TRAP still honoured)
//  BR_TAKEN   in   1      conditional branch taken
//  BR_TARGET  in   WIDTH  branch target
//  JMP        in   1      unconditional jump to JMP_TARGET
//  CALL       in   1      jump to JMP_TARGET and push PC_OUT+INC onto RAS
//  JMP_TARGET in   WIDTH  jump/call target
//  RET        in   1      pop RAS into PC
//  TRAP       in   1      redirect to TRAP_VEC
//  PC_OUT     out  WIDTH  current PC (registered)
//  PC_NEXT    out  WIDTH  combinational value PC_OUT will take at next edge
//  RAS_EMPTY  out  1      RAS holds 0 entries
//  RAS_FULL   out  1      RAS holds RAS_DEPTH entries
//  RAS_UFLOW  out  1      one-cycle pulse: RET executed with RAS empty
//
// BEHAVIOUR
//  - Reset (RESET_N low, async): PC_OUT=RESET_VEC, RAS count=0, RAS_EMPTY=1,
//    RAS_FULL=0, RAS_UFLOW=0; RAS contents don't-care. Reset mid-operation
//    discards pending pushes/pops. First update on the first rising CLK
//    edge after RESET_N rises.
//  - Latency: requests sampled at rising edge, PC_OUT updates same edge
//    (1-cycle redirect). PC_NEXT is combinational from inputs and state.
//  - Priority per cycle (highest first): TRAP > STALL > RET > CALL > JMP >
//    BR_TAKEN > sequential. Lower requests in the same cycle are ignored.
//  - TRAP: PC<=TRAP_VEC; RAS unchanged; honoured even with STALL=1.
//  - STALL (no TRAP): PC_OUT and RAS hold; PC_NEXT=PC_OUT; RAS_UFLOW=0.
//  - Sequential: PC<=PC_OUT+INC, modulo 2^WIDTH (all-ones region wraps to 0).
//  - BR/JMP: PC<=target with bits [ALIGN_BITS-1:0] cleared.
//  - CALL: PC<=aligned JMP_TARGET; push (PC_OUT+INC) mod 2^WIDTH. RAS full:
//    circular overwrite of oldest entry, count stays RAS_DEPTH, RAS_FULL=1.
//  - RET, RAS non-empty: PC<=top entry; count-1.
//  - RET, RAS empty: PC<=TRAP_VEC; count stays 0; RAS_UFLOW=1 next cycle
//    only.
//  - RET+CALL together: RET wins; no push. Net one-pop per cycle maximum.
//  - RAS_EMPTY/RAS_FULL registered, derived from count, valid after reset.
//  - RAS stores WIDTH-bit values as pushed (no extra alignment on pop).
//
// TESTING
//  1 Reset then 4 free-running cycles, RESET_VEC=0 -> PC_OUT 0,4,8,12,16;
//    RAS_EMPTY=1.
//  2 PC=0x10, CALL JMP_TARGET=0x203 -> PC=0x200, RAS top=0x14; 3 seq cycles;
//    RET -> PC=0x14, RAS_EMPTY=1.
//  3 Five nested CALLs (DEPTH=4) then 5 RETs -> first 4 RETs return in LIFO
//    order, oldest address lost; 5th RET -> PC=0x80, RAS_UFLOW pulses 1 cycle.
//  4 STALL=1 with BR_TAKEN=1 -> PC held; same cycle TRAP=1 -> PC=0x80;
//    TRAP+RET+CALL together -> PC=0x80, RAS count unchanged.
//  5 PC=0xFFFF_FFFC sequential -> PC=0x0; assert RESET_N=0 mid-CALL (between
//    edges) -> PC_OUT=RESET_VEC at once, RAS_EMPTY=1, no push retained.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, sequential incrementer, prioritised
// next-PC selection and a circular return-address stack for call/return.
module pc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      INC        = 4,
  parameter int unsigned      ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC   = WIDTH'('h80),
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             ret_i,
  input  logic             trap_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_next_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_uflow_o
);

  localparam int unsigned      PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CNT_W      = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_V      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

  // One action per cycle, already resolved by priority.
  typedef enum logic [2:0] {
    ACT_SEQ,
    ACT_BR,
    ACT_JMP,
    ACT_CALL,
    ACT_RET,
    ACT_UFLOW,
    ACT_HOLD,
    ACT_TRAP
  } act_e;

  act_e             act;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, full_q;
  logic             uflow_q, uflow_d;
  logic             push_en;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - PTR_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] t);
    return t & ALIGN_MASK;
  endfunction

  assign pc_inc = pc_q + INC_V;

  always_comb begin
    act = ACT_SEQ;
    if (trap_i)                act = ACT_TRAP;
    else if (stall_i)          act = ACT_HOLD;
    else if (ret_i)            act = (cnt_q == '0) ? ACT_UFLOW : ACT_RET;
    else if (call_i)           act = ACT_CALL;
    else if (jmp_i)            act = ACT_JMP;
    else if (br_taken_i)       act = ACT_BR;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    uflow_d = 1'b0;
    push_en = 1'b0;
    unique case (act)
      ACT_TRAP:  pc_d = TRAP_VEC;
      ACT_HOLD:  pc_d = pc_q;
      ACT_RET: begin
        pc_d  = ras_mem_q[top_q];
        top_d = ptr_dec(top_q);
        cnt_d = cnt_q - CNT_W'(1);
      end
      ACT_UFLOW: begin
        pc_d    = TRAP_VEC;
        uflow_d = 1'b1;
      end
      ACT_CALL: begin
        // A full stack wraps onto its oldest slot; the count saturates.
        pc_d    = align(jmp_target_i);
        top_d   = ptr_inc(top_q);
        push_en = 1'b1;
        if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
      end
      ACT_JMP:   pc_d = align(jmp_target_i);
      ACT_BR:    pc_d = align(br_target_i);
      default:   pc_d = pc_inc;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_FULL);
      uflow_q <= uflow_d;
    end
  end

  // NOTE: the stack storage has no reset; validity is tracked by cnt_q alone,
  // which keeps the array a plain register file.
  always_ff @(posedge clk) begin
    if (push_en) ras_mem_q[top_d] <= pc_inc;
  end

  assign pc_o        = pc_q;
  assign pc_next_o   = pc_d;
  assign ras_empty_o = empty_q;
  assign ras_full_o  = full_q;
  assign ras_uflow_o = uflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus queues expected post-edge state, an
// independent monitor pops and compares it after each rising edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, br_taken_i, jmp_i, call_i, ret_i, trap_i;
  logic [31:0] br_target_i, jmp_target_i;
  logic [31:0] pc_o, pc_next_o;
  logic        ras_empty_o, ras_full_o, ras_uflow_o;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        uflow;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pc_next_snap;

  pc_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .jmp_i        (jmp_i),
    .call_i       (call_i),
    .jmp_target_i (jmp_target_i),
    .ret_i        (ret_i),
    .trap_i       (trap_i),
    .pc_o         (pc_o),
    .pc_next_o    (pc_next_o),
    .ras_empty_o  (ras_empty_o),
    .ras_full_o   (ras_full_o),
    .ras_uflow_o  (ras_uflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    stall_i = 0; br_taken_i = 0; jmp_i = 0; call_i = 0; ret_i = 0; trap_i = 0;
    br_target_i = '0; jmp_target_i = '0;
  endtask

  // Drive one cycle of requests (called at a falling edge) and queue the
  // state expected after the following rising edge.
  task automatic step(input string name,
                      input logic st, input logic tr, input logic rt,
                      input logic cl, input logic jp, input logic br,
                      input logic [31:0] jt, input logic [31:0] bt,
                      input logic [31:0] e_pc, input logic e_empty,
                      input logic e_full, input logic e_uflow);
    exp_t e;
    stall_i = st; trap_i = tr; ret_i = rt; call_i = cl; jmp_i = jp; br_taken_i = br;
    jmp_target_i = jt; br_target_i = bt;
    e.name = name; e.pc = e_pc; e.empty = e_empty; e.full = e_full; e.uflow = e_uflow;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    #3;
    pc_next_snap = pc_next_o;
  end

  initial begin : monitor
    exp_t        e;
    logic [31:0] nxt;
    forever begin
      @(posedge clk);
      nxt = pc_next_snap;
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({e.name, ".pc_next"}, nxt, e.pc);
        check({e.name, ".pc"}, pc_o, e.pc);
        check_bit({e.name, ".empty"}, ras_empty_o, e.empty);
        check_bit({e.name, ".full"}, ras_full_o, e.full);
        check_bit({e.name, ".uflow"}, ras_uflow_o, e.uflow);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset.pc", pc_o, 32'h0);
    check("reset.pc_next", pc_next_o, 32'h4);
    check_bit("reset.empty", ras_empty_o, 1'b1);
    check_bit("reset.full", ras_full_o, 1'b0);
    check_bit("reset.uflow", ras_uflow_o, 1'b0);
    rst_n = 1'b1;

    //    name        st tr rt cl jp br  jmp_tgt       br_tgt        exp_pc      em fu uf
    step("seq1",      0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h4,       1, 0, 0);
    step("seq2",      0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8,       1, 0, 0);
    step("seq3",      0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hC,       1, 0, 0);
    step("seq4",      0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h10,      1, 0, 0);

    step("call",      0, 0, 0, 1, 0, 0, 32'h203,      32'h0,        32'h200,     0, 0, 0);
    step("cseq1",     0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h204,     0, 0, 0);
    step("cseq2",     0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h208,     0, 0, 0);
    step("cseq3",     0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h20C,     0, 0, 0);
    step("ret",       0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h14,      1, 0, 0);

    step("nest_c1",   0, 0, 0, 1, 0, 0, 32'h1000,     32'h0,        32'h1000,    0, 0, 0);
    step("nest_c2",   0, 0, 0, 1, 0, 0, 32'h2000,     32'h0,        32'h2000,    0, 0, 0);
    step("nest_c3",   0, 0, 0, 1, 0, 0, 32'h3000,     32'h0,        32'h3000,    0, 0, 0);
    step("nest_c4",   0, 0, 0, 1, 0, 0, 32'h4000,     32'h0,        32'h4000,    0, 1, 0);
    step("nest_c5",   0, 0, 0, 1, 0, 0, 32'h5000,     32'h0,        32'h5000,    0, 1, 0);
    step("nest_r1",   0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h4004,    0, 0, 0);
    step("nest_r2",   0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h3004,    0, 0, 0);
    step("nest_r3",   0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h2004,    0, 0, 0);
    step("nest_r4",   0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h1004,    1, 0, 0);
    step("nest_r5",   0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h80,      1, 0, 1);
    step("uf_clear",  0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h84,      1, 0, 0);

    step("pri_call",  0, 0, 0, 1, 0, 0, 32'h301,      32'h0,        32'h300,     0, 0, 0);
    step("stall_br",  1, 0, 0, 0, 0, 1, 32'h0,        32'h600,      32'h300,     0, 0, 0);
    step("stall_trap",1, 1, 0, 0, 0, 1, 32'h0,        32'h600,      32'h80,      0, 0, 0);
    step("trap_rc",   0, 1, 1, 1, 0, 0, 32'h900,      32'h0,        32'h80,      0, 0, 0);
    step("ret_kept",  0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h88,      1, 0, 0);
    step("stall_ret", 1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h88,      1, 0, 0);
    step("retcall_e", 0, 0, 1, 1, 0, 0, 32'hA00,      32'h0,        32'h80,      1, 0, 1);
    step("retcall_2", 0, 0, 1, 1, 0, 0, 32'hA00,      32'h0,        32'h80,      1, 0, 1);
    step("jmp",       0, 0, 0, 0, 1, 0, 32'h457,      32'h0,        32'h454,     1, 0, 0);
    step("br",        0, 0, 0, 0, 0, 1, 32'h0,        32'h1237,     32'h1234,    1, 0, 0);
    step("jmp_br",    0, 0, 0, 0, 1, 1, 32'h2000,     32'h3000,     32'h2000,    1, 0, 0);

    step("to_top",    0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0,       32'hFFFF_FFFC, 1, 0, 0);
    step("wrap",      0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,       1, 0, 0);
    step("pre_call",  0, 0, 0, 1, 0, 0, 32'h700,      32'h0,        32'h700,     0, 0, 0);

    // Reset asserted between edges while a CALL is being requested.
    if (sb_q.size() != 0) check("drain_before_reset", 32'(sb_q.size()), 32'h0);
    call_i = 1'b1;
    jmp_target_i = 32'h800;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.pc", pc_o, 32'h0);
    check_bit("midrst.empty", ras_empty_o, 1'b1);
    check_bit("midrst.full", ras_full_o, 1'b0);
    check_bit("midrst.uflow", ras_uflow_o, 1'b0);
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_ret", 0, 0, 1, 0, 0, 0, 32'h0,     32'h0,        32'h80,      1, 0, 1);
    step("post_rst_seq", 0, 0, 0, 0, 0, 0, 32'h0,     32'h0,        32'h84,      1, 0, 0);
    idle();

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) check("final_drain", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
